// File: rtl/pair_exit_receiver.sv
// Pair-exit frame receiver: samples one word per frame, filters null/malformed words, buffers payloads in a DEPTH-entry FIFO.
// Latency 1 from sample cycle to out_valid; drops on full without pop. Optional stats: define PAIR_RX_STATS_EN.
module pair_exit_receiver #(
  parameter int FRAME_LEN    = 16,
  parameter int SAMPLE_PHASE = 1,
  parameter int DEPTH        = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [226:0] in,
  input  logic         qempty,
  output logic [225:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         frame_tick,
  output logic         overflow,
  output logic         proto_err
`ifdef PAIR_RX_STATS_EN
  ,
  output logic [15:0]  rx_pairs,
  output logic [15:0]  rx_nulls,
  output logic [15:0]  rx_drops
`endif
);

  localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] LAST  = CW'(FRAME_LEN - 1);
  localparam logic [CW-1:0] PHASE = CW'(SAMPLE_PHASE);

  logic [CW-1:0]  cnt;
  logic [AW:0]    wr_ptr, rd_ptr;
  logic [225:0]   mem [DEPTH];
  logic           sample, is_null, is_bad, is_valid;
  logic           empty, full, pop, push, drop;

  // Gated by reset so the tick is low during reset even if the phase equals the reset count.
  assign sample     = reset && (cnt == PHASE);
  assign frame_tick = sample;

  assign is_null  = qempty || (in == {1'b1, 226'b0});
  assign is_bad   = !qempty && in[226] && (in[225:0] != '0);
  assign is_valid = sample && !is_null && !is_bad;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = !empty && out_ready;
  assign push  = is_valid && (!full || pop);
  assign drop  = is_valid && full && !pop;

  assign out_valid = !empty;
  assign out_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= LAST;
    end else begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (drop) overflow <= 1'b1;
      if (sample && is_bad) proto_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= in[225:0];
  end

`ifdef PAIR_RX_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_pairs <= '0;
      rx_nulls <= '0;
      rx_drops <= '0;
    end else begin
      if (push && rx_pairs != 16'hFFFF) rx_pairs <= rx_pairs + 1'b1;
      if (sample && is_null && rx_nulls != 16'hFFFF) rx_nulls <= rx_nulls + 1'b1;
      if (drop && rx_drops != 16'hFFFF) rx_drops <= rx_drops + 1'b1;
    end
  end
`endif

endmodule

// File: doc/pair_exit_receiver.md
PAIR_EXIT_RECEIVER -- requirements
Module: pair_exit_receiver

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 16: cycles per pair-exit frame; one word is offered per frame.
REQ-002 SHALL have parameter SAMPLE_PHASE, default 1: frame-counter value at which the input word is sampled, 0..FRAME_LEN-1.
REQ-003 SHALL have parameter DEPTH, default 4: output buffer depth in entries, power of two, 2..16.
REQ-004 SHALL have port clk, in, 1: single clock; all flops rise on posedge.
REQ-005 SHALL have port reset, in, 1: asynchronous active-low reset (0 = reset), with synchronous deassertion handled externally.
REQ-006 SHALL have port in, in, 227: pair word from the exit FIFO; bit 226 is the null marker; bits 225:0 are the payload.
REQ-007 SHALL have port qempty, in, 1: exit FIFO empty flag, frame-registered by the sender.
REQ-008 SHALL have port out_data, out, 226: payload of the head buffered pair.
REQ-009 SHALL have port out_valid, out, 1: out_data holds a valid pair.
REQ-010 SHALL have port out_ready, in, 1: the consumer accepts the pair.
REQ-011 SHALL have port frame_tick, out, 1: one-cycle pulse in the sample cycle.
REQ-012 SHALL have port overflow, out, 1: sticky flag, set when a pair is dropped.
REQ-013 SHALL have port proto_err, out, 1: sticky flag, set on a malformed null word.

Function
REQ-014 SHALL keep a frame counter 0..FRAME_LEN-1 that increments each cycle and wraps to 0 after FRAME_LEN-1.
- Counter resets to FRAME_LEN-1 so it stays phase-aligned with a sender released from reset in the same cycle.
REQ-015 SHALL pulse frame_tick and sample in and qempty only when counter == SAMPLE_PHASE.
REQ-016 SHALL classify a sampled word:
- null if qempty=1 or in == {1'b1, 226'b0};
- malformed if in[226]=1, payload nonzero and qempty=0;
- valid otherwise.
REQ-017 SHALL discard null and malformed words; a malformed word also sets proto_err.
REQ-018 SHALL push a valid word's payload into a DEPTH-entry FIFO.
- The word is visible on out_data/out_valid the cycle after the sample cycle (latency 1).
REQ-019 SHALL pop the head on out_valid && out_ready; out_valid=0 whenever the FIFO is empty; out_data holds when not popped.
REQ-020 SHALL drop a valid word sampled while the FIFO is full and no pop occurs that cycle, and set overflow.
REQ-021 SHALL accept a push and a pop in the same cycle even when the FIFO is full; occupancy is unchanged.
REQ-022 SHALL wrap read and write pointers modulo DEPTH and use an extra occupancy bit to distinguish full from empty.
REQ-023 SHALL clear overflow and proto_err only on reset.

Reset
REQ-024 SHALL, on reset low, immediately set: counter=FRAME_LEN-1, FIFO empty, out_valid=0, out_data=0, frame_tick=0, overflow=0, proto_err=0.
REQ-025 SHALL discard buffered pairs if reset is asserted mid-operation; the first sample after release occurs SAMPLE_PHASE+1 cycles after release.

Configuration
REQ-026 SHALL support macro PAIR_RX_STATS_EN.
- When defined: 16-bit saturating output counters rx_pairs (valid words pushed), rx_nulls (null frames) and rx_drops (dropped words), all reset to 0.
- When undefined: these ports and counters do not exist; all other behaviour is identical.

Verification
REQ-027 SHALL cover: reset release, in = payload 0x5 with qempty=0 held -> first frame_tick at cycle 2; out_valid=1 with out_data=0x5 at cycle 3.
REQ-028 SHALL cover: qempty=1 for 3 frames -> out_valid stays 0, no flags set; with STATS, rx_nulls=3.
REQ-029 SHALL cover: out_ready=0, 5 consecutive valid frames with DEPTH=4 -> 4 buffered in order, 5th dropped, overflow=1; with STATS, rx_drops=1.
REQ-030 SHALL cover: FIFO full, out_ready=1 in a sample cycle carrying a valid word -> pop and push both occur, occupancy stays 4, overflow stays 0.
REQ-031 SHALL cover: in = {1'b1, 226'h1}, qempty=0 -> word discarded, proto_err=1 and held until reset.
REQ-032 SHALL cover: reset asserted asynchronously mid-frame with 2 entries buffered -> out_valid=0 in the same cycle and counter=FRAME_LEN-1.
